bound_flasher_seq: RTL and testbench

//  Parametrised LED bound flasher. It drives an N_LED-wide thermometer bar up and down through a

---
 rtl/bound_flasher_pkg.sv | 26 ++
 rtl/bound_flasher_if.sv | 32 +++
 rtl/bound_flasher_seq_sync.sv | 28 ++
 rtl/bound_flasher_seq.sv | 175 +++++++++++++++++
 tb/tb_bound_flasher_seq.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bound_flasher_pkg.sv
// Shared types and helpers for the bound flasher: state encoding, table field width,
// thermometer decode and target clamping.
package bound_flasher_pkg;

    localparam int unsigned SEG_FIELD_W = 8;
    localparam int unsigned THERMO_W    = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } state_e;

    // Thermometer code (1<<lvl)-1, wide enough for any supported bar width.
    function automatic logic [THERMO_W-1:0] thermo(input int unsigned lvl);
        if (lvl >= THERMO_W) begin
            return '1;
        end
        return (THERMO_W'(1) << lvl) - THERMO_W'(1);
    endfunction

    function automatic int unsigned clamp_tgt(input int unsigned raw, input int unsigned n_led);
        return (raw > n_led) ? n_led : raw;
    endfunction

endpackage

// File: rtl/bound_flasher_if.sv
// Board-side bus of the bound flasher: flick button in, LED bar and status out.
// The cfg_* table-write port exists only when BOUND_FLASHER_PROG_EN is defined.
interface bound_flasher_if #(
    parameter int unsigned N_LED = 16,
    parameter int unsigned N_SEG = 6
);
    localparam int unsigned SW = $clog2(N_SEG);
    localparam int unsigned LW = $clog2(N_LED + 1);

    logic             flick;
    logic [N_LED-1:0] led;
    logic             busy;
    logic [SW-1:0]    seg_idx;
    logic             done;

`ifdef BOUND_FLASHER_PROG_EN
    logic             cfg_we;
    logic [SW-1:0]    cfg_addr;
    logic [LW-1:0]    cfg_data;

    modport master (output flick, cfg_we, cfg_addr, cfg_data,
                    input  led, busy, seg_idx, done);
    modport slave  (input  flick, cfg_we, cfg_addr, cfg_data,
                    output led, busy, seg_idx, done);
`else
    modport master (output flick,
                    input  led, busy, seg_idx, done);
    modport slave  (input  flick,
                    output led, busy, seg_idx, done);
`endif

endinterface

// File: rtl/bound_flasher_seq_sync.sv
// flick_sync_edge: two-flop synchroniser for the asynchronous flick button followed by
// a rising-edge detector; pulse is high for one clock per low-to-high transition.
module flick_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic pulse
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign pulse = sync_q & ~prev_q;

endmodule

// File: rtl/bound_flasher_seq.sv
// Bound flasher: walks a thermometer LED bar up and down through a table of segment
// targets. Define BOUND_FLASHER_PROG_EN to make the target table writable over cfg_*.
module bound_flasher_seq
    import bound_flasher_pkg::*;
#(
    parameter int unsigned                      N_LED     = 16,
    parameter int unsigned                      N_SEG     = 6,
    parameter logic [N_SEG*SEG_FIELD_W-1:0]     SEG_TGT   = {8'd0, 8'd6, 8'd0, 8'd11, 8'd6, 8'd16},
    parameter logic [N_LED:0]                   KICK_MASK = 17'h00041,
    parameter int unsigned                      TICK_DIV  = 1
) (
    input  logic          clk,
    input  logic          reset,
    bound_flasher_if.slave bus
);

    localparam int unsigned SW    = $clog2(N_SEG);
    localparam int unsigned LW    = $clog2(N_LED + 1);
    localparam int unsigned PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned TBL_N = 1 << SW;

    state_e           state_q, state_d;
    logic [LW-1:0]    lvl_q,   lvl_d;
    logic [SW-1:0]    seg_q,   seg_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [N_LED-1:0] led_q,   led_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;

    logic             flick_evt_c;
    logic             tick_c;
    logic             kick_ok_c;
    logic             last_seg_c;
    logic [LW-1:0]    cur_tgt_c;
    logic [LW-1:0]    tgt_tbl [TBL_N];

    // Reset/constant value of one table entry; entries past N_SEG read as zero.
    function automatic logic [LW-1:0] rom_tgt(input int unsigned i);
        if (i >= N_SEG) begin
            return '0;
        end
        return LW'(clamp_tgt(32'(SEG_TGT[i*SEG_FIELD_W +: SEG_FIELD_W]), N_LED));
    endfunction

    flick_sync_edge u_flick_sync (
        .clk   (clk),
        .reset (reset),
        .din   (bus.flick),
        .pulse (flick_evt_c)
    );

`ifdef BOUND_FLASHER_PROG_EN
    logic [LW-1:0] tgt_q [TBL_N];

    // Table writes only land while idle so a running sequence sees a stable table.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < TBL_N; i++) begin
                tgt_q[i] <= rom_tgt(i);
            end
        end else if (bus.cfg_we && !busy_q && (32'(bus.cfg_addr) < N_SEG)) begin
            tgt_q[bus.cfg_addr] <= bus.cfg_data;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < TBL_N; i++) begin
            tgt_tbl[i] = LW'(clamp_tgt(32'(tgt_q[i]), N_LED));
        end
    end
`else
    always_comb begin
        for (int unsigned i = 0; i < TBL_N; i++) begin
            tgt_tbl[i] = rom_tgt(i);
        end
    end
`endif

    assign cur_tgt_c  = tgt_tbl[seg_q];
    assign last_seg_c = (seg_q == SW'(N_SEG - 1));
    assign tick_c     = (state_q != IDLE) && (presc_q == PW'(TICK_DIV - 1));
    assign kick_ok_c  = KICK_MASK[lvl_q] && !last_seg_c;

    // Next-state logic: a flick event outranks the step tick.
    always_comb begin
        state_d = state_q;
        lvl_d   = lvl_q;
        seg_d   = seg_q;
        done_d  = 1'b0;
        presc_d = presc_q;

        if (state_q == IDLE || tick_c) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PW'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (flick_evt_c) begin
                    state_d = UP;
                    seg_d   = '0;
                    lvl_d   = '0;
                end
            end
            UP: begin
                if (tick_c) begin
                    if (lvl_q < cur_tgt_c) begin
                        lvl_d = lvl_q + LW'(1);
                    end else if (last_seg_c) begin
                        state_d = IDLE;
                        lvl_d   = '0;
                        seg_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        seg_d   = seg_q + SW'(1);
                        state_d = DOWN;
                    end
                end
            end
            DOWN: begin
                if (flick_evt_c && kick_ok_c) begin
                    state_d = UP;
                    seg_d   = seg_q - SW'(1);
                end else if (tick_c) begin
                    if (lvl_q > cur_tgt_c) begin
                        lvl_d = lvl_q - LW'(1);
                    end else if (last_seg_c) begin
                        state_d = IDLE;
                        lvl_d   = '0;
                        seg_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        seg_d   = seg_q + SW'(1);
                        state_d = UP;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                lvl_d   = '0;
                seg_d   = '0;
            end
        endcase

        led_d  = N_LED'(thermo(32'(lvl_d)));
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            lvl_q   <= '0;
            seg_q   <= '0;
            presc_q <= '0;
            led_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lvl_q   <= lvl_d;
            seg_q   <= seg_d;
            presc_q <= presc_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.led     = led_q;
    assign bus.busy    = busy_q;
    assign bus.seg_idx = seg_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_bound_flasher_seq.sv
// Bench for bound_flasher_seq: randomised flick traffic checked cycle by cycle against a
// segment-walk reference model through an expected-output queue, plus timing checks.
module tb_bound_flasher_seq;

    localparam int N_LED = 16;
    localparam int N_SEG = 6;
    localparam logic [N_LED:0] KICK = 17'h00041;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    bound_flasher_if #(.N_LED(N_LED), .N_SEG(N_SEG)) bif  ();
    bound_flasher_if #(.N_LED(N_LED), .N_SEG(N_SEG)) bif4 ();

    bound_flasher_seq #(.N_LED(N_LED), .N_SEG(N_SEG)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    bound_flasher_seq #(.N_LED(N_LED), .N_SEG(N_SEG), .TICK_DIV(4)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bif4)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: even segments climb, odd segments fall, targets from the table.
    typedef struct {
        logic [N_LED-1:0] led;
        int               seg;
        bit               busy;
        bit               done;
    } exp_t;

    exp_t exp_q[$];
    int   m_tgt[N_SEG] = '{16, 6, 11, 0, 6, 0};
    bit   m_run  = 1'b0;
    int   m_lvl  = 0;
    int   m_seg  = 0;
    bit   m_done = 1'b0;
    bit   h1 = 1'b0, h2 = 1'b0, h3 = 1'b0;

    function automatic logic [N_LED-1:0] bar(input int lvl);
        logic [N_LED-1:0] b = '0;
        for (int i = 0; i < lvl; i++) b[i] = 1'b1;
        return b;
    endfunction

    task automatic model_step();
        bit evt;
        evt = h2 && !h3;
        h3  = h2;
        h2  = h1;
        h1  = bif.flick;
        m_done = 1'b0;
`ifdef BOUND_FLASHER_PROG_EN
        if (bif.cfg_we && !m_run && int'(bif.cfg_addr) < N_SEG)
            m_tgt[bif.cfg_addr] = (int'(bif.cfg_data) > N_LED) ? N_LED : int'(bif.cfg_data);
`endif
        if (!m_run) begin
            if (evt) begin
                m_run = 1'b1;
                m_lvl = 0;
                m_seg = 0;
            end
        end else if (evt && (m_seg % 2 == 1) && m_seg != N_SEG - 1 && KICK[m_lvl]) begin
            m_seg--;
        end else if (m_seg % 2 == 0) begin
            if (m_lvl < m_tgt[m_seg]) m_lvl++;
            else m_seg++;
        end else if (m_lvl > m_tgt[m_seg]) begin
            m_lvl--;
        end else if (m_seg == N_SEG - 1) begin
            m_run  = 1'b0;
            m_lvl  = 0;
            m_seg  = 0;
            m_done = 1'b1;
        end else begin
            m_seg++;
        end
        exp_q.push_back('{led: bar(m_lvl), seg: m_seg, busy: m_run, done: m_done});
    endtask

    initial begin : model
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                m_run = 1'b0; m_lvl = 0; m_seg = 0; m_done = 1'b0;
                h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
            end else begin
                model_step();
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                chk("reset_outputs", 64'({bif.led, bif.seg_idx, bif.busy, bif.done}), 64'(0));
            end else if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL sb_underflow: no expected entry at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                chk("sb_led",  64'(bif.led),          64'(e.led));
                chk("sb_seg",  64'(bif.seg_idx),      64'(e.seg));
                chk("sb_busy", 64'(bif.busy),         64'(e.busy));
                chk("sb_done", 64'(bif.done),         64'(e.done));
            end
        end
    end

    // Stimulus changes land 2 time units after the falling edge.
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    task automatic pulse(input int w);
        bif.flick = 1'b1;
        cycles(w);
        bif.flick = 1'b0;
    endtask

    task automatic wait_led(input logic [N_LED-1:0] v, input int seg, input int budget, input string name);
        int n = 0;
        while (!(bif.led == v && int'(bif.seg_idx) == seg && bif.busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(n < budget), 64'(1));
        #2;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (bif.busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(n < budget), 64'(1));
        #2;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n, m;
        logic [N_LED-1:0] prev;
        bif.flick  = 1'b0;
        bif4.flick = 1'b0;
`ifdef BOUND_FLASHER_PROG_EN
        bif.cfg_we  = 1'b0; bif.cfg_addr  = '0; bif.cfg_data  = '0;
        bif4.cfg_we = 1'b0; bif4.cfg_addr = '0; bif4.cfg_data = '0;
`endif
        cycles(3);
        reset = 1'b1;
        cycles(6);

        // Full run: start latency and run length in clocks.
        bif.flick = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!bif.busy && n < 10);
        chk("start_latency", 64'(n), 64'(3));
        bif.flick = 1'b0;
        m = 0;
        do begin @(posedge clk); #1; m++; end while (!bif.done && m < 200);
        chk("done_after_ticks", 64'(m), 64'(60));
        cycles(2);
        chk("idle_after_done", 64'(bif.busy), 64'(0));

        // Kickback from the first down segment at level 6.
        pulse(1);
        wait_led(16'h00FF, 1, 100, "reach_down_lvl8");
        pulse(1);
        cycles(2);
        chk("kick_seg", 64'(bif.seg_idx), 64'(0));
        chk("kick_led", 64'(bif.led), 64'(16'h003F));
        wait_led(16'hFFFF, 0, 40, "kick_reclimb");
        wait_idle(200, "kick_run_end");
        cycles(3);

        // Ignored flicks: while climbing, and while falling at level 8.
        pulse(1);
        wait_led(16'h000F, 0, 20, "reach_up_lvl4");
        pulse(1);
        wait_led(16'h03FF, 1, 100, "reach_down_lvl10");
        pulse(1);
        cycles(2);
        chk("ignored_seg", 64'(bif.seg_idx), 64'(1));
        chk("ignored_led", 64'(bif.led), 64'(16'h007F));
        wait_idle(200, "ignored_run_end");
        cycles(3);

        // Held flick gives a single start.
        bif.flick = 1'b1;
        wait_led(16'h0001, 0, 10, "held_start");
        wait_idle(200, "held_run_end");
        cycles(20);
        chk("held_no_restart", 64'(bif.busy), 64'(0));
        bif.flick = 1'b0;
        cycles(4);

        // Asynchronous reset mid-run.
        pulse(1);
        wait_led(16'h01FF, 0, 40, "reach_lvl9");
        reset = 1'b0;
        #1;
        chk("async_reset_led",  64'(bif.led),  64'(0));
        chk("async_reset_busy", 64'(bif.busy), 64'(0));
        chk("async_reset_done", 64'(bif.done), 64'(0));
        cycles(3);
        reset = 1'b1;
        cycles(5);

`ifdef BOUND_FLASHER_PROG_EN
        bif.cfg_we = 1'b1; bif.cfg_addr = 3'd0; bif.cfg_data = 5'd4;
        cycles(1);
        bif.cfg_addr = 3'd7; bif.cfg_data = 5'd2;
        cycles(1);
        bif.cfg_we = 1'b0;
        pulse(1);
        wait_led(16'h000F, 0, 20, "prog_peak");
        cycles(1);
        chk("prog_peak_hold", 64'(bif.led), 64'(16'h000F));
        bif.cfg_we = 1'b1; bif.cfg_addr = 3'd2; bif.cfg_data = 5'd1;
        cycles(1);
        bif.cfg_we = 1'b0;
        wait_idle(200, "prog_run_end");
        cycles(3);
`endif

        // Randomised flick traffic.
        for (int k = 0; k < 40; k++) begin
            cycles(int'($urandom_range(1, 60)));
            pulse(int'($urandom_range(1, 4)));
        end
        cycles(4);
        wait_idle(400, "random_drain");
        cycles(2);

        // Divided tick: one step every 4 clocks.
        bif4.flick = 1'b1;
        n = 0;
        while (!bif4.busy && n < 10) begin @(negedge clk); n++; end
        chk("t4_start", 64'(bif4.busy), 64'(1));
        #2;
        bif4.flick = 1'b0;
        prev = bif4.led;
        for (int k = 0; k < 8; k++) begin
            n = 0;
            do begin @(negedge clk); n++; end while (bif4.led == prev && n < 20);
            chk("t4_interval", 64'(n), 64'(4));
            chk("t4_level", 64'(bif4.led), 64'(bar(k + 1)));
            prev = bif4.led;
        end
        chk("t4_seg",  64'(bif4.seg_idx), 64'(0));
        chk("t4_done", 64'(bif4.done),    64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
